// File: rtl/spell_mem_arb_pkg.sv
// Shared definitions for the SPELL memory port arbiter.
// State codes, owner encoding and grant constants.
package spell_mem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CORE = 2'd1;
    localparam logic [1:0] ST_DBG  = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_CORE = 2'b01;
    localparam logic [1:0] GRANT_DBG  = 2'b10;

    localparam int CNT_W = 4;

endpackage

// File: rtl/spell_mem_arb_pick.sv
// Next-owner selection for the SPELL memory arbiter.
// Debug priority with burst limit, or round-robin.
module spell_mem_arb_pick
    import spell_mem_arb_pkg::*;
#(
    parameter int DEBUG_PRIORITY  = 1,
    parameter int MAX_DEBUG_BURST = 4
) (
    input  logic             core_req,
    input  logic             dbg_req,
    input  logic [CNT_W-1:0] burst_cnt,
    input  logic             last_dbg,
    output logic             pick_valid,
    output logic             pick_dbg
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DEBUG_BURST);

    // Resolve a single winner; ties go by priority/burst or alternation
    always_comb begin
        pick_valid = core_req | dbg_req;
        pick_dbg   = 1'b0;
        if (dbg_req && !core_req) begin
            pick_dbg = 1'b1;
        end else if (dbg_req && core_req) begin
            if (DEBUG_PRIORITY != 0)
                pick_dbg = (burst_cnt < MAX_CNT);
            else
                pick_dbg = !last_dbg;
        end
    end

endmodule

// File: rtl/spell_mem_arbiter.sv
// Shares the SPELL memory port between the core and the debug host.
// Whole-transaction ownership with a one-cycle idle gap between owners.
module spell_mem_arbiter
    import spell_mem_arb_pkg::*;
#(
    parameter int DEBUG_PRIORITY  = 1,
    parameter int MAX_DEBUG_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       core_select,
    input  logic [7:0] core_addr,
    input  logic [7:0] core_data_in,
    input  logic       core_memory_type_data,
    input  logic       core_write,
    output logic       core_data_ready,
    input  logic       dbg_select,
    input  logic [7:0] dbg_addr,
    input  logic [7:0] dbg_data_in,
    input  logic       dbg_memory_type_data,
    input  logic       dbg_write,
    output logic       dbg_data_ready,
    output logic       mem_select,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data_in,
    output logic       mem_memory_type_data,
    output logic       mem_write,
    input  logic       mem_data_ready,
    input  logic [7:0] mem_data_out,
    output logic [7:0] data_out,
    output logic [1:0] grant
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DEBUG_BURST);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] burst_cnt;
    owner_t           last_owner;
    logic             pick_valid;
    logic             pick_dbg;

    spell_mem_arb_pick #(
        .DEBUG_PRIORITY (DEBUG_PRIORITY),
        .MAX_DEBUG_BURST(MAX_DEBUG_BURST)
    ) u_pick (
        .core_req  (core_select),
        .dbg_req   (dbg_select),
        .burst_cnt (burst_cnt),
        .last_dbg  (last_owner == OWN_DBG),
        .pick_valid(pick_valid),
        .pick_dbg  (pick_dbg)
    );

    // Transaction sequencing: grant from IDLE, hold until select drops
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pick_valid) state_nxt = pick_dbg ? ST_DBG : ST_CORE;
            ST_CORE: if (!core_select) state_nxt = ST_GAP;
            ST_DBG:  if (!dbg_select) state_nxt = ST_GAP;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, debug burst count and last owner, updated on grant entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            burst_cnt  <= '0;
            last_owner <= OWN_DBG;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && state_nxt == ST_DBG) begin
                last_owner <= OWN_DBG;
                if (burst_cnt < MAX_CNT)
                    burst_cnt <= burst_cnt + 1'b1;
            end
            if (state == ST_IDLE && state_nxt == ST_CORE) begin
                last_owner <= OWN_CORE;
                burst_cnt  <= '0;
            end
        end
    end

    // Port mux: the owner drives the memory, everything else is quiet
    always_comb begin
        mem_select           = 1'b0;
        mem_addr             = 8'h00;
        mem_data_in          = 8'h00;
        mem_memory_type_data = 1'b0;
        mem_write            = 1'b0;
        core_data_ready      = 1'b0;
        dbg_data_ready       = 1'b0;
        grant                = GRANT_NONE;
        case (state)
            ST_CORE: begin
                mem_select           = core_select;
                mem_addr             = core_addr;
                mem_data_in          = core_data_in;
                mem_memory_type_data = core_memory_type_data;
                mem_write            = core_write;
                core_data_ready      = mem_data_ready;
                grant                = GRANT_CORE;
            end
            ST_DBG: begin
                mem_select           = dbg_select;
                mem_addr             = dbg_addr;
                mem_data_in          = dbg_data_in;
                mem_memory_type_data = dbg_memory_type_data;
                mem_write            = dbg_write;
                dbg_data_ready       = mem_data_ready;
                grant                = GRANT_DBG;
            end
            default: ;
        endcase
    end

    assign data_out = mem_data_out;

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Directed testbench for spell_mem_arbiter.
// Two instances: debug priority (burst 2) and round-robin.
module tb_spell_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       core_select = 1'b0;
    logic [7:0] core_addr = 8'h00;
    logic [7:0] core_data_in = 8'h00;
    logic       core_memory_type_data = 1'b0;
    logic       core_write = 1'b0;
    logic       core_data_ready;
    logic       dbg_select = 1'b0;
    logic [7:0] dbg_addr = 8'h00;
    logic [7:0] dbg_data_in = 8'h00;
    logic       dbg_memory_type_data = 1'b0;
    logic       dbg_write = 1'b0;
    logic       dbg_data_ready;
    logic       mem_select;
    logic [7:0] mem_addr;
    logic [7:0] mem_data_in;
    logic       mem_memory_type_data;
    logic       mem_write;
    logic       mem_data_ready;
    logic [7:0] mem_data_out;
    logic [7:0] data_out;
    logic [1:0] grant;

    logic       rr_core_select = 1'b0;
    logic       rr_dbg_select = 1'b0;
    logic       rr_core_data_ready;
    logic       rr_dbg_data_ready;
    logic       rr_mem_select;
    logic [7:0] rr_mem_addr;
    logic [7:0] rr_mem_data_in;
    logic       rr_mem_memory_type_data;
    logic       rr_mem_write;
    logic       rr_mem_data_ready;
    logic [7:0] rr_mem_data_out;
    logic [7:0] rr_data_out;
    logic [1:0] rr_grant;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spell_mem_arbiter #(.DEBUG_PRIORITY(1), .MAX_DEBUG_BURST(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_select(core_select), .core_addr(core_addr),
        .core_data_in(core_data_in),
        .core_memory_type_data(core_memory_type_data),
        .core_write(core_write), .core_data_ready(core_data_ready),
        .dbg_select(dbg_select), .dbg_addr(dbg_addr),
        .dbg_data_in(dbg_data_in),
        .dbg_memory_type_data(dbg_memory_type_data),
        .dbg_write(dbg_write), .dbg_data_ready(dbg_data_ready),
        .mem_select(mem_select), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in),
        .mem_memory_type_data(mem_memory_type_data),
        .mem_write(mem_write), .mem_data_ready(mem_data_ready),
        .mem_data_out(mem_data_out), .data_out(data_out),
        .grant(grant)
    );

    spell_mem_arbiter #(.DEBUG_PRIORITY(0), .MAX_DEBUG_BURST(2)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .core_select(rr_core_select), .core_addr(core_addr),
        .core_data_in(core_data_in),
        .core_memory_type_data(core_memory_type_data),
        .core_write(core_write), .core_data_ready(rr_core_data_ready),
        .dbg_select(rr_dbg_select), .dbg_addr(dbg_addr),
        .dbg_data_in(dbg_data_in),
        .dbg_memory_type_data(dbg_memory_type_data),
        .dbg_write(dbg_write), .dbg_data_ready(rr_dbg_data_ready),
        .mem_select(rr_mem_select), .mem_addr(rr_mem_addr),
        .mem_data_in(rr_mem_data_in),
        .mem_memory_type_data(rr_mem_memory_type_data),
        .mem_write(rr_mem_write), .mem_data_ready(rr_mem_data_ready),
        .mem_data_out(rr_mem_data_out), .data_out(rr_data_out),
        .grant(rr_grant)
    );

    // Memory models: ready one cycle after select, data = addr ^ 0x5A
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_data_ready    <= 1'b0;
            rr_mem_data_ready <= 1'b0;
        end else begin
            mem_data_ready    <= mem_select;
            rr_mem_data_ready <= rr_mem_select;
        end
    end

    assign mem_data_out    = mem_addr ^ 8'h5A;
    assign rr_mem_data_out = rr_mem_addr ^ 8'h5A;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic dbg_txn;
        dbg_select = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            if (dbg_data_ready) break;
            tick();
        end
        check("dbg_txn_rdy", {7'd0, dbg_data_ready}, 8'h01);
        dbg_select = 1'b0;
        tick();
        tick();
    endtask

    logic [1:0] seq_p [6];
    logic [1:0] seq_r [6];
    logic [1:0] exp_p [6];
    logic [1:0] exp_r [6];
    int         n_p;
    int         n_r;
    logic [1:0] prev_p;
    logic [1:0] prev_r;

    initial begin
        exp_p = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
        exp_r = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

        // reset state
        #3;
        check("rst_grant", {6'd0, grant}, 8'h00);
        check("rst_msel", {7'd0, mem_select}, 8'h00);
        check("rst_dout", data_out, 8'h5A);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // core read alone
        core_addr = 8'h12;
        core_memory_type_data = 1'b1;
        core_select = 1'b1;
        check("cr_idle_grant", {6'd0, grant}, 8'h00);
        tick();
        check("cr_grant", {6'd0, grant}, 8'h01);
        check("cr_addr", mem_addr, 8'h12);
        check("cr_type", {7'd0, mem_memory_type_data}, 8'h01);
        check("cr_msel", {7'd0, mem_select}, 8'h01);
        check("cr_rdy0", {7'd0, core_data_ready}, 8'h00);
        tick();
        check("cr_rdy1", {7'd0, core_data_ready}, 8'h01);
        check("cr_dout", data_out, 8'h48);
        check("cr_dbg_rdy", {7'd0, dbg_data_ready}, 8'h00);
        core_select = 1'b0;
        tick();
        check("cr_gap_grant", {6'd0, grant}, 8'h00);
        check("cr_gap_msel", {7'd0, mem_select}, 8'h00);
        tick();
        check("cr_idle2", {6'd0, grant}, 8'h00);

        // contention: priority instance and round-robin instance
        do_reset();
        core_addr = 8'h20;
        dbg_addr = 8'h40;
        core_select = 1'b1;
        dbg_select = 1'b1;
        rr_core_select = 1'b1;
        rr_dbg_select = 1'b1;
        n_p = 0;
        n_r = 0;
        prev_p = 2'b00;
        prev_r = 2'b00;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (grant != 2'b00 && prev_p == 2'b00 && n_p < 6) begin
                seq_p[n_p] = grant;
                n_p++;
            end
            if (rr_grant != 2'b00 && prev_r == 2'b00 && n_r < 6) begin
                seq_r[n_r] = rr_grant;
                n_r++;
            end
            prev_p = grant;
            prev_r = rr_grant;
            if (grant == 2'b00)
                check("pri_gap_msel", {7'd0, mem_select}, 8'h00);
            if (rr_grant == 2'b01)
                check("rr_dbg_rdy", {7'd0, rr_dbg_data_ready}, 8'h00);
            core_select = !core_data_ready;
            dbg_select = !dbg_data_ready;
            rr_core_select = !rr_core_data_ready;
            rr_dbg_select = !rr_dbg_data_ready;
        end
        check("pri_count", n_p[7:0], 8'd6);
        check("rr_count", n_r[7:0], 8'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < n_p) check($sformatf("pri_seq%0d", i),
                               {6'd0, seq_p[i]}, {6'd0, exp_p[i]});
            if (i < n_r) check($sformatf("rr_seq%0d", i),
                               {6'd0, seq_r[i]}, {6'd0, exp_r[i]});
        end
        core_select = 1'b0;
        dbg_select = 1'b0;
        rr_core_select = 1'b0;
        rr_dbg_select = 1'b0;
        tick();
        tick();
        tick();

        // debug write with core request arriving mid-transaction
        do_reset();
        dbg_addr = 8'hFF;
        dbg_data_in = 8'hA5;
        dbg_memory_type_data = 1'b0;
        dbg_write = 1'b1;
        dbg_select = 1'b1;
        check("dw_idle_wr", {7'd0, mem_write}, 8'h00);
        tick();
        check("dw_grant", {6'd0, grant}, 8'h02);
        check("dw_wr", {7'd0, mem_write}, 8'h01);
        check("dw_addr", mem_addr, 8'hFF);
        check("dw_data", mem_data_in, 8'hA5);
        check("dw_type", {7'd0, mem_memory_type_data}, 8'h00);
        core_addr = 8'h33;
        core_write = 1'b0;
        core_select = 1'b1;
        check("dw_hold_grant", {6'd0, grant}, 8'h02);
        tick();
        check("dw_rdy", {7'd0, dbg_data_ready}, 8'h01);
        check("dw_core_rdy", {7'd0, core_data_ready}, 8'h00);
        dbg_select = 1'b0;
        dbg_write = 1'b0;
        tick();
        check("dw_gap_grant", {6'd0, grant}, 8'h00);
        check("dw_gap_wr", {7'd0, mem_write}, 8'h00);
        tick();
        check("dw_idle_grant", {6'd0, grant}, 8'h00);
        tick();
        check("dw_core_grant", {6'd0, grant}, 8'h01);
        check("dw_core_wr", {7'd0, mem_write}, 8'h00);
        tick();
        check("dw_core_rdy1", {7'd0, core_data_ready}, 8'h01);
        check("dw_core_dout", data_out, 8'h69);
        core_select = 1'b0;
        tick();
        tick();

        // early abort by the core
        do_reset();
        core_select = 1'b1;
        tick();
        check("ab_grant", {6'd0, grant}, 8'h01);
        check("ab_rdy0", {7'd0, core_data_ready}, 8'h00);
        core_select = 1'b0;
        tick();
        check("ab_gap_grant", {6'd0, grant}, 8'h00);
        check("ab_gap_rdy", {7'd0, core_data_ready}, 8'h00);
        check("ab_gap_msel", {7'd0, mem_select}, 8'h00);
        tick();
        check("ab_idle_grant", {6'd0, grant}, 8'h00);
        check("ab_idle_rdy", {7'd0, core_data_ready}, 8'h00);

        // async reset during a debug transaction; burst count must clear
        do_reset();
        dbg_addr = 8'h07;
        dbg_txn();
        dbg_txn();
        dbg_select = 1'b1;
        tick();
        check("ar_grant", {6'd0, grant}, 8'h02);
        tick();
        check("ar_rdy", {7'd0, dbg_data_ready}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        check("ar_rst_grant", {6'd0, grant}, 8'h00);
        check("ar_rst_msel", {7'd0, mem_select}, 8'h00);
        check("ar_rst_rdy", {7'd0, dbg_data_ready}, 8'h00);
        check("ar_rst_dout", data_out, 8'h5A);
        core_select = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ar_post_grant", {6'd0, grant}, 8'h02);
        check("ar_post_addr", mem_addr, 8'h07);
        dbg_select = 1'b0;
        core_select = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
